tone_detector: RTL and testbench

- Receive-side counterpart of the piano square-wave note generators.
- Samples a 1-bit square wave, such as the speaker line looped back or a comparator output. Measures its half-period in clk cycles and classifies it against the seven-note table (Do..Si).
- Reports a stable note code once the same note has been seen on LOCK_CNT consecutive half-periods.
- Sits between the audio input pin and the display/score logic.

---
 rtl/tone_detector_pkg.sv | 38 +++
 rtl/tone_detector_if.sv | 19 +
 rtl/tone_detector_note_matcher.sv | 36 +++
 rtl/tone_detector.sv | 160 ++++++++++++++++
 tb/tb_tone_detector.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tone_detector_pkg.sv
// Shared constants for the tone detector.
//   Note codes : NOTE_DO..NOTE_SI (0..6), NOTE_NONE (7).
//   HP_*       : half-period in 50 MHz clk cycles. These are the same toggle
//                compares the square-wave note generators use.
//   HP_TABLE   : the HP_* values packed so that index == note code.
//   state_t    : detector FSM states.
package tone_detector_pkg;

  localparam int NUM_NOTES = 7;

  localparam logic [2:0] NOTE_DO   = 3'd0;
  localparam logic [2:0] NOTE_RE   = 3'd1;
  localparam logic [2:0] NOTE_MI   = 3'd2;
  localparam logic [2:0] NOTE_FA   = 3'd3;
  localparam logic [2:0] NOTE_SOL  = 3'd4;
  localparam logic [2:0] NOTE_LA   = 3'd5;
  localparam logic [2:0] NOTE_SI   = 3'd6;
  localparam logic [2:0] NOTE_NONE = 3'd7;

  localparam logic [31:0] HP_DO  = 32'd95556;
  localparam logic [31:0] HP_RE  = 32'd85133;
  localparam logic [31:0] HP_MI  = 32'd75843;
  localparam logic [31:0] HP_FA  = 32'd71586;
  localparam logic [31:0] HP_SOL = 32'd63776;
  localparam logic [31:0] HP_LA  = 32'd56818;
  localparam logic [31:0] HP_SI  = 32'd50619;

  // The leftmost element is index 6 (Si), so HP_TABLE[code] is that note's entry.
  localparam logic [NUM_NOTES-1:0][31:0] HP_TABLE =
    {HP_SI, HP_LA, HP_SOL, HP_FA, HP_MI, HP_RE, HP_DO};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

endpackage

// File: rtl/tone_detector_if.sv
// Detector-side signal bundle.
//   tone_in     : raw square-wave input (asynchronous to clk)
//   note        : note code, 7 = none
//   note_valid  : high while locked
//   note_strobe : one-cycle pulse when a lock is acquired
//   period      : last measured half-period in clk cycles
// master = the side that drives the tone; slave = the detector.
interface tone_detector_if #(
  parameter int CNT_W = 19
);
  logic             tone_in;
  logic [2:0]       note;
  logic             note_valid;
  logic             note_strobe;
  logic [CNT_W-1:0] period;

  modport master (output tone_in, input note, note_valid, note_strobe, period);
  modport slave  (input tone_in, output note, note_valid, note_strobe, period);
endinterface

// File: rtl/tone_detector_note_matcher.sv
// Combinational classifier: maps a measured half-period to a note code.
//   measured : half-period in clk cycles
//   cls      : lowest note code whose table entry lies within +/-TOL, else 7
// HP_TAB defaults to the 50 MHz table and can be overridden for other clocks.
module note_matcher
  import tone_detector_pkg::*;
#(
  parameter int                          CNT_W  = 19,
  parameter int                          TOL    = 1024,
  parameter logic [NUM_NOTES-1:0][31:0]  HP_TAB = HP_TABLE
) (
  input  logic [CNT_W-1:0] measured,
  output logic [2:0]       cls
);

  localparam logic [31:0] TOL_W = 32'(TOL);

  logic [31:0]          m;
  logic [NUM_NOTES-1:0] hit;

  assign m = 32'(measured);

  // Distance is always taken as larger minus smaller, so it never underflows.
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_cmp
    assign hit[g] = (m >= HP_TAB[g]) ? ((m - HP_TAB[g]) <= TOL_W)
                                     : ((HP_TAB[g] - m) <= TOL_W);
  end

  // Scan from the top down so the lowest matching code wins.
  always_comb begin
    cls = NOTE_NONE;
    for (int i = NUM_NOTES - 1; i >= 0; i--)
      if (hit[i]) cls = 3'(i);
  end

endmodule

// File: rtl/tone_detector.sv
// Square-wave tone detector.
//   clk, rst : system clock and asynchronous active-high reset
//   bus      : tone_detector_if slave. It carries tone_in in and
//              note / note_valid / note_strobe / period out.
// The input passes through a 2-FF synchronizer and a previous-sample register.
// Either edge of the synchronized input closes one half-period measurement.
// A note locks after LOCK_CNT consecutive matching half-periods. The lock drops
// on the first mismatch, or after TIMEOUT cycles with no edge.
module tone_detector
  import tone_detector_pkg::*;
#(
  parameter int                          CNT_W    = 19,
  parameter int                          TOL      = 1024,
  parameter int                          LOCK_CNT = 4,
  parameter int                          TIMEOUT  = 524287,
  parameter logic [NUM_NOTES-1:0][31:0]  HP_TAB   = HP_TABLE
) (
  input  logic           clk,
  input  logic           rst,
  tone_detector_if.slave bus
);

  localparam int               MC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TO_W   = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  LOCK_W = MC_W'(LOCK_CNT);

  logic             s1, s2, prev;
  logic             tone_edge;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cls;

  state_t           state, state_n;
  logic [2:0]       cand, cand_n;
  logic [MC_W-1:0]  mcnt, mcnt_n;
  logic [2:0]       note_q, note_n;
  logic             valid_q, valid_n;
  logic             strobe_q, strobe_n;
  logic [CNT_W-1:0] period_q, period_n;
  logic             timeout;

  // Input path: two synchronizer stages, then a previous sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= bus.tone_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign tone_edge = s2 ^ prev;

  // Counts cycles since the last edge. On an edge it restarts at 1, so on the
  // next edge it holds exactly the interval. It saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (tone_edge)     cnt <= CNT_W'(1);
    else if (cnt != TO_W)   cnt <= cnt + CNT_W'(1);
  end

  note_matcher #(
    .CNT_W  (CNT_W),
    .TOL    (TOL),
    .HP_TAB (HP_TAB)
  ) u_match (
    .measured (cnt),
    .cls      (cls)
  );

  assign timeout = (state != ST_IDLE) && (cnt == TO_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cand     <= NOTE_NONE;
      mcnt     <= '0;
      note_q   <= NOTE_NONE;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      period_q <= '0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      mcnt     <= mcnt_n;
      note_q   <= note_n;
      valid_q  <= valid_n;
      strobe_q <= strobe_n;
      period_q <= period_n;
    end
  end

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    mcnt_n   = mcnt;
    note_n   = note_q;
    valid_n  = valid_q;
    strobe_n = 1'b0;
    period_n = period_q;

    if (timeout) begin
      // Silence drops everything, and period keeps its last value. An edge
      // arriving in this same cycle becomes the first edge of a fresh
      // measurement, so the FSM goes straight to MEASURE.
      state_n = tone_edge ? ST_MEASURE : ST_IDLE;
      valid_n = 1'b0;
      note_n  = NOTE_NONE;
      cand_n  = NOTE_NONE;
      mcnt_n  = '0;
    end else if (tone_edge) begin
      unique case (state)
        ST_IDLE: begin
          // The first edge only starts timing.
          state_n = ST_MEASURE;
          cand_n  = NOTE_NONE;
          mcnt_n  = '0;
        end
        ST_MEASURE: begin
          period_n = cnt;
          if (cls == NOTE_NONE) begin
            cand_n = NOTE_NONE;
            mcnt_n = '0;
          end else if (cls == cand) begin
            mcnt_n = mcnt + MC_W'(1);
          end else begin
            cand_n = cls;
            mcnt_n = MC_W'(1);
          end
          if (mcnt_n == LOCK_W) begin
            state_n  = ST_LOCKED;
            note_n   = cand_n;
            valid_n  = 1'b1;
            strobe_n = 1'b1;
          end
        end
        ST_LOCKED: begin
          period_n = cnt;
          if (cls != note_q) begin
            // The mismatching interval becomes the first vote for the new candidate.
            state_n = ST_MEASURE;
            valid_n = 1'b0;
            note_n  = NOTE_NONE;
            cand_n  = cls;
            mcnt_n  = (cls == NOTE_NONE) ? '0 : MC_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.note        = note_q;
  assign bus.note_valid  = valid_q;
  assign bus.note_strobe = strobe_q;
  assign bus.period      = period_q;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector. The note table is scaled by 1/256 (TOL=4,
// TIMEOUT=1023) so that full lock/unlock/timeout scenarios fit in a short run.
module tb_tone_detector;
  import tone_detector_pkg::*;

  localparam int CNT_W    = 19;
  localparam int TOL      = 4;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 1023;
  localparam int H_DO = 373, H_RE = 332, H_MI = 296, H_FA = 279;
  localparam int H_SOL = 249, H_LA = 221, H_SI = 197;
  localparam logic [6:0][31:0] TB_TAB =
    {32'd197, 32'd221, 32'd249, 32'd279, 32'd296, 32'd332, 32'd373};

  int tab [7] = '{H_DO, H_RE, H_MI, H_FA, H_SOL, H_LA, H_SI};

  logic clk = 1'b0;
  logic rst;

  tone_detector_if #(.CNT_W(CNT_W)) bus();

  tone_detector #(
    .CNT_W(CNT_W), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .HP_TAB(TB_TAB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;

  // Event-level reference model. It stamps each observed edge with its cycle
  // number. An interval is the difference between two stamps, classified
  // against the table, and it feeds a run of identical classifications.
  int       m_mode;   // 0 silent, 1 hunting, 2 locked
  int       m_cand, m_run, m_note, m_last, m_period, m_cyc;
  bit       m_valid, m_strobe;
  bit [4:0] dl;       // tone_in history, 3-cycle input latency plus one

  function automatic int classify(input int v);
    for (int i = 0; i < 7; i++)
      if (((v > tab[i]) ? v - tab[i] : tab[i] - v) <= TOL) return i;
    return 7;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cand = 7; m_run = 0; m_note = 7; m_last = 0;
    m_period = 0; m_cyc = 0; m_valid = 0; m_strobe = 0; dl = '0;
  endtask

  task automatic model_step();
    bit e;
    int d, c;
    if (rst) begin
      model_reset();
      return;
    end
    dl = {dl[3:0], bus.tone_in};
    e  = dl[3] ^ dl[4];
    m_cyc++;
    m_strobe = 0;
    d = m_cyc - m_last;
    if (m_mode != 0 && d >= TIMEOUT) begin
      m_mode = e ? 1 : 0; m_valid = 0; m_note = 7; m_cand = 7; m_run = 0;
      m_last = m_cyc;
    end else if (e) begin
      if (m_mode != 0) begin
        c = classify(d);
        m_period = d;
        if (m_mode == 2) begin
          if (c != m_note) begin
            m_mode = 1; m_valid = 0; m_note = 7; m_cand = c; m_run = (c == 7) ? 0 : 1;
          end
        end else begin
          if (c == 7) begin m_cand = 7; m_run = 0; end
          else if (c == m_cand) m_run++;
          else begin m_cand = c; m_run = 1; end
          if (m_run == LOCK_CNT) begin
            m_mode = 2; m_note = c; m_valid = 1; m_strobe = 1;
          end
        end
      end else m_mode = 1;
      m_last = m_cyc;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, m_cyc, act, exp);
    end
  endtask

  // One clock: at the falling edge, advance the model and compare every output.
  // Then move on to just after the next rising edge, where stimulus changes.
  task automatic cyc();
    @(negedge clk);
    model_step();
    chk("note", int'(bus.note), m_note);
    chk("note_valid", int'(bus.note_valid), int'(m_valid));
    chk("note_strobe", int'(bus.note_strobe), int'(m_strobe));
    chk("period", int'(bus.period), m_period);
    if (bus.note_strobe) n_strobe++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) cyc();
  endtask

  // n toggles, each followed by h cycles, so consecutive edges are h apart.
  task automatic play(input int h, input int n);
    repeat (n) begin
      bus.tone_in = ~bus.tone_in;
      wait_cycles(h);
    end
  endtask

  initial begin
    int s0, idx, len, reps, jit;
    rst = 1'b1;
    bus.tone_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_note", int'(bus.note), 7);
    chk("rst_valid", int'(bus.note_valid), 0);
    chk("rst_strobe", int'(bus.note_strobe), 0);
    chk("rst_period", int'(bus.period), 0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(5);

    // Re lock: valid rises on the third rising edge after the 5th toggle.
    s0 = n_strobe;
    play(H_RE, 4);
    bus.tone_in = ~bus.tone_in;
    wait_cycles(2);
    chk("re_prelock_valid", int'(bus.note_valid), 0);
    cyc();
    chk("re_lock_valid", int'(bus.note_valid), 1);
    chk("re_lock_strobe", int'(bus.note_strobe), 1);
    chk("re_lock_note", int'(bus.note), 1);
    chk("re_lock_period", int'(bus.period), 332);
    cyc();
    chk("re_strobe_single", int'(bus.note_strobe), 0);
    wait_cycles(H_RE - 3);
    play(H_RE, 3);
    chk("re_strobe_count", n_strobe - s0, 1);

    // Silence ends the lock.
    wait_cycles(TIMEOUT + 10);
    chk("silence_valid", int'(bus.note_valid), 0);

    // Tolerance edges around La.
    play(H_LA + TOL, 6);
    chk("la_tol_note", int'(bus.note), 5);
    chk("la_tol_valid", int'(bus.note_valid), 1);
    wait_cycles(TIMEOUT + 10);
    play(H_LA + TOL + 1, 8);
    chk("la_over_valid", int'(bus.note_valid), 0);
    chk("la_over_note", int'(bus.note), 7);
    chk("la_over_period", int'(bus.period), 226);
    wait_cycles(TIMEOUT + 10);

    // Sol lock, then switch to Mi.
    s0 = n_strobe;
    play(H_SOL, 6);
    chk("sol_note", int'(bus.note), 4);
    play(H_MI, 1);
    bus.tone_in = ~bus.tone_in;
    wait_cycles(2);
    chk("mi_drop_pre", int'(bus.note_valid), 1);
    cyc();
    chk("mi_drop", int'(bus.note_valid), 0);
    wait_cycles(H_MI - 3);
    play(H_MI, 3);
    chk("mi_note", int'(bus.note), 2);
    chk("mi_valid", int'(bus.note_valid), 1);
    chk("solmi_strobes", n_strobe - s0, 2);

    // Do lock, then an edge exactly as the counter saturates restarts timing.
    wait_cycles(TIMEOUT + 10);
    play(H_DO, 6);
    chk("do_note", int'(bus.note), 0);
    wait_cycles(TIMEOUT - H_DO);
    play(H_DO, 5);
    chk("do_relock_at_timeout", int'(bus.note_valid), 1);
    wait_cycles(TIMEOUT + 10);

    // Glitch while locked on Si.
    play(H_SI, 6);
    chk("si_lock", int'(bus.note), 6);
    bus.tone_in = ~bus.tone_in;
    wait_cycles(20);
    bus.tone_in = ~bus.tone_in;
    wait_cycles(H_SI);
    chk("glitch_drop", int'(bus.note_valid), 0);
    play(H_SI, 3);
    chk("glitch_3match", int'(bus.note_valid), 0);
    play(H_SI, 1);
    chk("glitch_relock", int'(bus.note_valid), 1);
    chk("glitch_relock_note", int'(bus.note), 6);
    wait_cycles(TIMEOUT + 10);

    // Asynchronous reset while locked on Fa.
    play(H_FA, 6);
    chk("fa_lock", int'(bus.note), 3);
    #2;
    rst = 1'b1;
    bus.tone_in = 1'b0;
    #1;
    chk("arst_note", int'(bus.note), 7);
    chk("arst_valid", int'(bus.note_valid), 0);
    chk("arst_period", int'(bus.period), 0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(5);
    play(H_FA, 4);
    chk("arst_first_edge_ignored", int'(bus.note_valid), 0);
    play(H_FA, 1);
    chk("arst_relock", int'(bus.note_valid), 1);

    // Randomized segments: notes with jitter, odd intervals, occasional silence.
    for (int k = 0; k < 30; k++) begin
      idx  = $urandom_range(0, 8);
      reps = $urandom_range(1, 7);
      for (int r = 0; r < reps; r++) begin
        if (idx >= 7) len = $urandom_range(20, 400);
        else begin
          jit = $urandom_range(0, 2 * (TOL + 2));
          len = tab[idx] + jit - (TOL + 2);
        end
        play(len, 1);
      end
      if ($urandom_range(0, 9) == 0) wait_cycles(TIMEOUT + 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
